// File: rtl/id_ex_stage.sv
// ID/EX pipeline register.
// Holds the decoded instruction for the execute stage. Detects load-use
// hazards against the instruction in ID, inserts a single bubble for each
// one, and counts the bubbles in a saturating counter.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_reg_write,
  input  logic              in_mem_to_reg,
  input  logic              in_branch,
  input  logic              in_jump,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic              in_alu_src,
  input  logic              in_reg_dst,
  input  logic              in_uses_rt,
  input  logic [1:0]        in_alu_op,
  input  logic [DATA_W-1:0] in_rd1,
  input  logic [DATA_W-1:0] in_rd2,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [DATA_W-1:0] in_pc4,
  input  logic [REG_AW-1:0] in_rs,
  input  logic [REG_AW-1:0] in_rt,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              flush,
  output logic              out_valid,
  output logic              out_reg_write,
  output logic              out_mem_to_reg,
  output logic              out_branch,
  output logic              out_jump,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              out_alu_src,
  output logic              out_reg_dst,
  output logic [1:0]        out_alu_op,
  output logic [DATA_W-1:0] out_rd1,
  output logic [DATA_W-1:0] out_rd2,
  output logic [DATA_W-1:0] out_imm,
  output logic [DATA_W-1:0] out_pc4,
  output logic [REG_AW-1:0] out_rs,
  output logic [REG_AW-1:0] out_rt,
  output logic [REG_AW-1:0] out_rd,
  output logic              hold,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              r_valid, r_reg_write, r_mem_to_reg, r_branch, r_jump;
  logic              r_mem_read, r_mem_write, r_alu_src, r_reg_dst;
  logic [1:0]        r_alu_op;
  logic [DATA_W-1:0] r_rd1, r_rd2, r_imm, r_pc4;
  logic [REG_AW-1:0] r_rs, r_rt, r_rd;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic w_haz;
  logic w_bubble;
  logic w_count;

  // Load in EX writes a nonzero register that the ID instruction reads.
  always_comb begin
    w_haz    = in_valid & r_valid & r_mem_read & (r_rt != '0) &
               ((r_rt == in_rs) | (in_uses_rt & (r_rt == in_rt)));
    // A flush discards the ID instruction, so there is nothing to hold.
    hold     = w_haz & ~flush;
    w_bubble = flush | w_haz;
    w_count  = hold & (r_stall_cnt != '1);
  end

  // Control half: reset, bubble (flush or hazard) or load from decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_branch     <= 1'b0;
      r_jump       <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_alu_src    <= 1'b0;
      r_reg_dst    <= 1'b0;
      r_alu_op     <= 2'b00;
    end else if (w_bubble) begin
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_branch     <= 1'b0;
      r_jump       <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_alu_src    <= 1'b0;
      r_reg_dst    <= 1'b0;
      r_alu_op     <= 2'b00;
    end else begin
      r_valid      <= in_valid;
      r_reg_write  <= in_reg_write;
      r_mem_to_reg <= in_mem_to_reg;
      r_branch     <= in_branch;
      r_jump       <= in_jump;
      r_mem_read   <= in_mem_read;
      r_mem_write  <= in_mem_write;
      r_alu_src    <= in_alu_src;
      r_reg_dst    <= in_reg_dst;
      r_alu_op     <= in_alu_op;
    end
  end

  // Data half: bubbles leave operands untouched since they are don't-care.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd1 <= '0;
      r_rd2 <= '0;
      r_imm <= '0;
      r_pc4 <= '0;
      r_rs  <= '0;
      r_rt  <= '0;
      r_rd  <= '0;
    end else if (!w_bubble) begin
      r_rd1 <= in_rd1;
      r_rd2 <= in_rd2;
      r_imm <= in_imm;
      r_pc4 <= in_pc4;
      r_rs  <= in_rs;
      r_rt  <= in_rt;
      r_rd  <= in_rd;
    end
  end

  // Saturating count of hazard bubbles; flushed hazards are not stalls.
  always_ff @(posedge clk) begin
    if (rst)          r_stall_cnt <= '0;
    else if (w_count) r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  assign out_valid      = r_valid;
  assign out_reg_write  = r_reg_write;
  assign out_mem_to_reg = r_mem_to_reg;
  assign out_branch     = r_branch;
  assign out_jump       = r_jump;
  assign out_mem_read   = r_mem_read;
  assign out_mem_write  = r_mem_write;
  assign out_alu_src    = r_alu_src;
  assign out_reg_dst    = r_reg_dst;
  assign out_alu_op     = r_alu_op;
  assign out_rd1        = r_rd1;
  assign out_rd2        = r_rd2;
  assign out_imm        = r_imm;
  assign out_pc4        = r_pc4;
  assign out_rs         = r_rs;
  assign out_rt         = r_rt;
  assign out_rd         = r_rd;
  assign stall_cnt      = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed cases with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_id_ex_stage;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 2;
  localparam int CMAX   = (1 << CNT_W) - 1;

  typedef struct packed {
    logic              valid, reg_write, mem_to_reg, branch, jump;
    logic              mem_read, mem_write, alu_src, reg_dst;
    logic [1:0]        alu_op;
    logic [DATA_W-1:0] rd1, rd2, imm, pc4;
    logic [REG_AW-1:0] rs, rt, rd;
  } ins_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic uses_rt = 1'b0;
  ins_t st = '0;

  logic              out_valid, out_reg_write, out_mem_to_reg, out_branch, out_jump;
  logic              out_mem_read, out_mem_write, out_alu_src, out_reg_dst;
  logic [1:0]        out_alu_op;
  logic [DATA_W-1:0] out_rd1, out_rd2, out_imm, out_pc4;
  logic [REG_AW-1:0] out_rs, out_rt, out_rd;
  logic              hold;
  logic [CNT_W-1:0]  stall_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(st.valid), .in_reg_write(st.reg_write), .in_mem_to_reg(st.mem_to_reg),
    .in_branch(st.branch), .in_jump(st.jump), .in_mem_read(st.mem_read),
    .in_mem_write(st.mem_write), .in_alu_src(st.alu_src), .in_reg_dst(st.reg_dst),
    .in_uses_rt(uses_rt), .in_alu_op(st.alu_op),
    .in_rd1(st.rd1), .in_rd2(st.rd2), .in_imm(st.imm), .in_pc4(st.pc4),
    .in_rs(st.rs), .in_rt(st.rt), .in_rd(st.rd), .flush(flush),
    .out_valid(out_valid), .out_reg_write(out_reg_write), .out_mem_to_reg(out_mem_to_reg),
    .out_branch(out_branch), .out_jump(out_jump), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_alu_src(out_alu_src), .out_reg_dst(out_reg_dst),
    .out_alu_op(out_alu_op), .out_rd1(out_rd1), .out_rd2(out_rd2), .out_imm(out_imm),
    .out_pc4(out_pc4), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .hold(hold), .stall_cnt(stall_cnt)
  );

  ins_t dut_ex;
  assign dut_ex = '{out_valid, out_reg_write, out_mem_to_reg, out_branch, out_jump,
                    out_mem_read, out_mem_write, out_alu_src, out_reg_dst, out_alu_op,
                    out_rd1, out_rd2, out_imm, out_pc4, out_rs, out_rt, out_rd};

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  ins_t m_ex = '0;      // what execute should currently see
  int   m_cnt = 0;
  bit   m_ok = 0;       // model meaningful once a reset edge has happened

  // An instruction in ID must wait if the load in EX produces a
  // nonzero register it reads.
  function automatic bit must_wait(input ins_t ex, input ins_t id, input logic urt);
    bit reads_rs, reads_rt;
    if (!(id.valid && ex.valid && ex.mem_read) || ex.rt == 0) return 0;
    reads_rs = (id.rs == ex.rt);
    reads_rt = urt && (id.rt == ex.rt);
    return reads_rs || reads_rt;
  endfunction

  always @(posedge clk) begin
    ins_t nx;
    bit   w;
    w  = must_wait(m_ex, st, uses_rt);
    nx = m_ex;
    if (rst) begin
      nx = '0;
      m_cnt <= 0;
      m_ok  <= 1;
    end else if (flush || w) begin
      // bubble: no instruction, no controls, operands left as they were
      {nx.valid, nx.reg_write, nx.mem_to_reg, nx.branch, nx.jump,
       nx.mem_read, nx.mem_write, nx.alu_src, nx.reg_dst} = '0;
      nx.alu_op = 2'b00;
      if (!flush && m_cnt < CMAX) m_cnt <= m_cnt + 1;
    end else begin
      nx = st;
    end
    m_ex <= nx;
  end

  // One compare process, on the falling edge.
  always @(negedge clk) begin
    if (m_ok) begin
      chk("ex_regs", 256'(dut_ex), 256'(m_ex));
      chk("hold", 256'(hold), 256'(must_wait(m_ex, st, uses_rt) && !flush));
      chk("stall_cnt", 256'(stall_cnt), 256'(m_cnt));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic ins_t lw(input logic [4:0] rs, input logic [4:0] rt);
    ins_t i = '0;
    i.valid = 1; i.mem_read = 1; i.mem_to_reg = 1; i.reg_write = 1; i.alu_src = 1;
    i.rs = rs; i.rt = rt; i.imm = 32'h10; i.pc4 = 32'h104;
    return i;
  endfunction

  function automatic ins_t add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    ins_t i = '0;
    i.valid = 1; i.reg_write = 1; i.reg_dst = 1; i.alu_op = 2'b10;
    i.rs = rs; i.rt = rt; i.rd = rd; i.rd1 = 32'h11; i.rd2 = 32'h22; i.pc4 = 32'h108;
    return i;
  endfunction

  task automatic do_reset();
    rst = 1; flush = 0; uses_rt = 0; st = '0;
    step();
    rst = 0;
  endtask

  initial begin
    // Reset with random inputs for two edges
    rst = 1;
    for (int c = 0; c < 2; c++) begin
      st = ins_t'({$urandom, $urandom, $urandom, $urandom, $urandom});
      flush = 1'($urandom); uses_rt = 1'($urandom);
      step();
      chk("rst_valid", 256'(out_valid), 256'(0));
      chk("rst_regs", 256'(dut_ex), 256'(0));
      chk("rst_cnt", 256'(stall_cnt), 256'(0));
    end
    rst = 0; st = '0; flush = 0; uses_rt = 0;
    #1;
    chk("rst_hold", 256'(hold), 256'(0));

    // Pass-through
    st = add(3, 4, 5); uses_rt = 1;
    #1 chk("pass_hold", 256'(hold), 256'(0));
    step();
    chk("pass_regs", 256'(dut_ex), 256'(add(3, 4, 5)));

    // Load-use on rs: one bubble then the held instruction advances
    do_reset();
    st = lw(1, 8); uses_rt = 0;
    step();
    st = add(8, 9, 10); uses_rt = 1;
    #1 chk("lu_hold1", 256'(hold), 256'(1));
    step();
    chk("lu_bubble_valid", 256'(out_valid), 256'(0));
    chk("lu_bubble_ctl", 256'({out_reg_write, out_mem_to_reg, out_mem_read, out_alu_src, out_alu_op}), 256'(0));
    chk("lu_cnt", 256'(stall_cnt), 256'(1));
    chk("lu_hold2", 256'(hold), 256'(0));
    step();
    chk("lu_adv_valid", 256'(out_valid), 256'(1));
    chk("lu_adv_rs", 256'(out_rs), 256'(8));
    chk("lu_adv_rd", 256'(out_rd), 256'(10));

    // No false stall: rt not used, and $0 destination
    do_reset();
    st = lw(1, 8); uses_rt = 0;
    step();
    st = add(3, 8, 6); uses_rt = 0;
    #1 chk("nfs_rt_hold", 256'(hold), 256'(0));
    step();
    st = lw(1, 0);
    step();
    st = add(0, 0, 7); uses_rt = 1;
    #1 chk("nfs_r0_hold", 256'(hold), 256'(0));
    step();
    chk("nfs_cnt", 256'(stall_cnt), 256'(0));

    // Flush during a hazard, then flush alone
    do_reset();
    st = lw(1, 8); uses_rt = 0;
    step();
    st = add(8, 9, 10); flush = 1;
    #1 chk("fh_hold", 256'(hold), 256'(0));
    step();
    chk("fh_valid", 256'(out_valid), 256'(0));
    chk("fh_cnt", 256'(stall_cnt), 256'(0));
    st = add(2, 3, 4); flush = 1;
    step();
    chk("fl_valid", 256'(out_valid), 256'(0));
    chk("fl_rw", 256'(out_reg_write), 256'(0));
    flush = 0;

    // Saturation: 5 load-use pairs -> 1,2,3,3,3
    do_reset();
    for (int k = 0; k < 5; k++) begin
      logic [1:0] want;
      want = (k < 3) ? 2'(k + 1) : 2'd3;
      st = lw(1, 8); uses_rt = 0;
      step();
      st = add(8, 1, 2);
      step();
      chk("sat_cnt", 256'(stall_cnt), 256'(want));
      step();
    end

    // Randomized traffic with narrow register indices to provoke hazards
    for (int c = 0; c < 3000; c++) begin
      ins_t r;
      r = ins_t'({$urandom, $urandom, $urandom, $urandom, $urandom});
      r.rs = 5'($urandom_range(0, 3));
      r.rt = 5'($urandom_range(0, 3));
      r.mem_read = ($urandom_range(0, 2) == 0);
      r.valid = ($urandom_range(0, 7) != 0);
      st = r;
      uses_rt = 1'($urandom);
      flush = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 0; flush = 0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register of the 5-stage CPU, with integrated load-use hazard detection and bubble insertion. It captures decoded control and operand fields from the decode stage each cycle and presents them to the execute stage. The Branch/Jump/MemtoReg controls it outputs continue down the pipe through the EX/MEM register. It also drives the stall handshake back to the PC and IF/ID registers, and keeps a saturating stall counter for performance debug.

## Interface
- DATA_W, 32, width of register operands, immediate and PC+4
- REG_AW, 5, register-index width
- CNT_W, 16, stall-counter width
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  ID slot holds a real instruction
- in_reg_write, in_mem_to_reg, in_branch, in_jump, in_mem_read, in_mem_write, in_alu_src, in_reg_dst, in_uses_rt  in  1 each  decoded controls (in_uses_rt: instruction reads rt as a source)
- in_alu_op  in  2  ALU op class
- in_rd1, in_rd2, in_imm, in_pc4  in  DATA_W each  operands, sign-extended immediate, PC+4
- in_rs, in_rt, in_rd  in  REG_AW each  register indices
- flush  in  1  branch/jump resolved taken downstream; kill the ID-stage instruction
- out_valid, out_reg_write, out_mem_to_reg, out_branch, out_jump, out_mem_read, out_mem_write, out_alu_src, out_reg_dst  out  1 each  registered controls
- out_alu_op  out  2
- out_rd1, out_rd2, out_imm, out_pc4  out  DATA_W each
- out_rs, out_rt, out_rd  out  REG_AW each
- hold  out  1  combinational; PC and IF/ID must not update this cycle
- stall_cnt  out  CNT_W  number of bubbles inserted for load-use hazards, saturating

## Operation
- Hazard (combinational): haz = in_valid & out_valid & out_mem_read & (out_rt != 0) & ((out_rt == in_rs) | (in_uses_rt & out_rt == in_rt)).
- hold = haz & ~flush.
- Next-state priority, evaluated at each clk edge:
  1. rst: all out_* registers and stall_cnt go to 0.
  2. flush: load a bubble.
  3. haz: load a bubble, and increment stall_cnt unless it is all ones.
  4. Otherwise: load every in_* field into the matching out_* field (out_valid <= in_valid).
- Bubble:
  - out_valid and all 1-bit controls go to 0; out_alu_op goes to 0.
  - Data and index fields (rd1, rd2, imm, pc4, rs, rt, rd) keep their previous values; they are don't-care while out_valid=0.
- in_valid=0 with no flush/haz loads in_* as given.
  - Decode must present zeroed controls when in_valid=0. The block does not gate them.
- A single load produces exactly one bubble. After the bubble, out_mem_read=0, so haz deasserts and the held instruction advances on the next edge.
- Back-to-back loads with a dependency each produce one bubble.
- A flush in the same cycle as haz inserts a bubble, drives hold=0 and does not count a stall; the wrong-path instruction is discarded.
- Register $0 as load destination never causes a stall.
- stall_cnt saturates at 2^CNT_W-1 and is not wrapped.

## Timing
- Latency: 1 cycle, in_* to out_*.
- hold is purely combinational from current out_* and in_* and flush, valid in the same cycle as the hazard. The PC and IF/ID registers sample it at the same edge at which this block inserts the bubble.
- Reset mid-stream: the next edge after rst=1 zeroes all outputs regardless of flush or haz. hold may be asserted during the rst cycle, which is harmless because upstream registers are also in reset.
- No internal state other than the out_* registers and stall_cnt; no FSM beyond the per-cycle priority mux.

## Test plan
- Reset: drive rst=1 for 2 cycles with random in_* -> all out_* = 0, stall_cnt = 0, hold = 0 after the first edge.
- Pass-through:
  - Stimulus: add with in_rs=3, in_rt=4, in_rd=5, in_rd1=0x11, in_rd2=0x22, in_reg_write=1, in_valid=1.
  - Required: identical values on out_* one edge later; hold = 0.
- Load-use on rs:
  - Stimulus: lw with rt=8 (mem_read=1) registered, then ID instruction with in_rs=8.
  - Required: hold=1 for exactly one cycle; next edge out_valid=0 with all controls 0; stall_cnt=1; the following edge the held instruction appears with out_valid=1.
- No false stall:
  - lw rt=8, then ID in_rt=8 with in_uses_rt=0 -> hold=0.
  - lw rt=0, then ID in_rs=0 -> hold=0.
  - Both cases: stall_cnt stays unchanged.
- Flush with hazard:
  - Stimulus: same setup as load-use on rs, plus flush=1 in the hazard cycle.
  - Required: hold=0; bubble loaded; stall_cnt unchanged.
  - Stimulus: flush=1 with no hazard.
  - Required: bubble loaded.
- Saturation:
  - Stimulus: CNT_W=2, 5 consecutive load-use pairs.
  - Required: stall_cnt steps 1, 2, 3, 3, 3.
